spike_dispatcher: RTL and testbench

- Transmit end of the spike source-address bus consumed by the per-neuron MAC units.
- Buffers fired-neuron addresses in a FIFO and drives them one at a time onto the shared source_address bus, with an idle gap between addresses.
- At each timestep boundary it drains the FIFO, then pulses clear so every MAC latches its spikes.
- Issues the set pulse that initialises all MACs after reset or on request.

---
 rtl/spike_dispatcher.sv | 243 ++++++++++++++++++++++++
 tb/tb_spike_dispatcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_dispatcher.sv
// ---------------------------------------------------------------------------
// spike_dispatcher
//
// Transmit end of the spike source-address bus feeding the per-neuron MAC
// units. Fired-neuron addresses are buffered in a small FIFO and driven one
// at a time onto the shared source_address bus. Each address is held for
// HOLD_CYCLES and followed by one idle cycle. At a timestep boundary the FIFO
// is drained, then clear_out is pulsed so every MAC latches its spikes. After
// reset, or on init_req, set_out is pulsed to initialise all MACs.
//
// Ports:
//   CLK             system clock
//   rst_n           asynchronous active-low reset
//   init_req        one-cycle request to re-run the set sequence (IDLE only)
//   spike_valid     spike_addr is valid this cycle
//   spike_addr      address of the fired neuron
//   spike_ready     FIFO not full and not initialising; transfer on valid&ready
//   timestep_end    one-cycle pulse marking the end of the timestep
//   set_out         MAC set strobe
//   clear_out       MAC clear strobe
//   source_address  shared address bus to the MACs (IDLE_ADDR when idle)
//   done            one-cycle pulse after clear_out falls
//   timestep_count  completed timesteps, wraps at 16'hFFFF
//   overflow        sticky; spike_valid seen while the FIFO was full
// ---------------------------------------------------------------------------
module spike_dispatcher #(
    parameter int                ADDR_W       = 12,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                HOLD_CYCLES  = 2,
    parameter int                CLEAR_CYCLES = 4,
    parameter int                SET_CYCLES   = 4,
    parameter logic [ADDR_W-1:0] IDLE_ADDR    = {ADDR_W{1'b1}}
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic              spike_valid,
    input  logic [ADDR_W-1:0] spike_addr,
    output logic              spike_ready,
    input  logic              timestep_end,
    output logic              set_out,
    output logic              clear_out,
    output logic [ADDR_W-1:0] source_address,
    output logic              done,
    output logic [15:0]       timestep_count,
    output logic              overflow
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int MAX_A   = (HOLD_CYCLES > CLEAR_CYCLES) ? HOLD_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYC = (MAX_A > SET_CYCLES) ? MAX_A : SET_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] SET_LAST   = TMR_W'(SET_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timerNext;
    logic                r_pending;
    logic                w_pendingNext;

    logic [ADDR_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    w_wrPtrNext;
    logic [PTR_W-1:0]    w_rdPtrNext;
    logic [CNT_W-1:0]    w_countNext;

    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_tsInc;
    logic                w_full;
    logic                w_empty;

    logic                r_setOut;
    logic                r_clearOut;
    logic                r_done;
    logic                r_ready;
    logic                r_overflow;
    logic [ADDR_W-1:0]   r_addrOut;
    logic [15:0]         r_tsCount;
    logic [ADDR_W-1:0]   w_addrNext;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = spike_valid && r_ready;

    // Next-state logic. GAP shares IDLE's dispatch decision on its exit edge,
    // so the gap between queued addresses is exactly one cycle. timestep_end
    // is OR-ed into the pending flag, so a repeat while already pending has
    // no further effect.
    always_comb begin
        w_stateNext   = r_state;
        w_timerNext   = r_timer;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        w_tsInc       = 1'b0;
        w_pendingNext = r_pending | timestep_end;
        case (r_state)
            ST_INIT: begin
                if (r_timer == SET_LAST) begin
                    w_stateNext = ST_IDLE;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + TMR_W'(1);
                end
            end
            ST_IDLE, ST_GAP: begin
                if ((r_state == ST_IDLE) && init_req) begin
                    w_flush       = 1'b1;
                    w_pendingNext = 1'b0;
                    w_stateNext   = ST_INIT;
                    w_timerNext   = '0;
                end else if (r_pending && w_empty) begin
                    w_stateNext = ST_CLEAR;
                    w_timerNext = '0;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_stateNext = ST_SEND;
                    w_timerNext = '0;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (r_timer == HOLD_LAST) begin
                    w_stateNext = ST_GAP;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + TMR_W'(1);
                end
            end
            ST_CLEAR: begin
                if (r_timer == CLEAR_LAST) begin
                    w_stateNext = ST_DONE;
                    w_timerNext = '0;
                    w_tsInc     = 1'b1;
                end else begin
                    w_timerNext = r_timer + TMR_W'(1);
                end
            end
            ST_DONE: begin
                w_stateNext   = ST_IDLE;
                w_pendingNext = 1'b0;
            end
            default: begin
                w_stateNext = ST_INIT;
                w_timerNext = '0;
            end
        endcase
    end

    // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
    // of two. A flush discards everything, including a push in the same cycle.
    always_comb begin
        w_wrPtrNext = r_wrPtr + PTR_W'(w_push);
        w_rdPtrNext = r_rdPtr + PTR_W'(w_pop);
        w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_flush) begin
            w_wrPtrNext = '0;
            w_rdPtrNext = '0;
            w_countNext = '0;
        end
    end

    // Bus value for the next cycle: a freshly popped head, the held address
    // while SEND continues, and IDLE_ADDR everywhere else.
    always_comb begin
        w_addrNext = IDLE_ADDR;
        if (w_pop) begin
            w_addrNext = r_mem[r_rdPtr];
        end else if (w_stateNext == ST_SEND) begin
            w_addrNext = r_addrOut;
        end
    end

    // FIFO storage carries no reset; losing its contents on reset is handled
    // by clearing the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= spike_addr;
        end
    end

    // State, FIFO pointers and all registered outputs. Outputs are decoded
    // from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_timer    <= '0;
            r_pending  <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_setOut   <= 1'b1;
            r_clearOut <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
            r_addrOut  <= IDLE_ADDR;
            r_tsCount  <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_timer    <= w_timerNext;
            r_pending  <= w_pendingNext;
            r_wrPtr    <= w_wrPtrNext;
            r_rdPtr    <= w_rdPtrNext;
            r_count    <= w_countNext;
            r_setOut   <= (w_stateNext == ST_INIT);
            r_clearOut <= (w_stateNext == ST_CLEAR);
            r_done     <= (w_stateNext == ST_DONE);
            r_ready    <= (w_countNext != FULL_CNT) && (w_stateNext != ST_INIT);
            r_overflow <= r_overflow | (spike_valid && w_full);
            r_addrOut  <= w_addrNext;
            r_tsCount  <= r_tsCount + 16'(w_tsInc);
        end
    end

    assign spike_ready    = r_ready;
    assign set_out        = r_setOut;
    assign clear_out      = r_clearOut;
    assign done           = r_done;
    assign overflow       = r_overflow;
    assign source_address = r_addrOut;
    assign timestep_count = r_tsCount;

endmodule

// File: tb/tb_spike_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_spike_dispatcher
//
// Self-checking bench for spike_dispatcher with default parameters. A table
// of per-cycle vectors covers reset exit, address sequencing and a timestep
// boundary; hand-written sequences cover FIFO fill/overflow, init_req and a
// reset in the middle of a send.
// ---------------------------------------------------------------------------
module tb_spike_dispatcher;

    typedef struct {
        logic        valid;
        logic [11:0] addr;
        logic        tend;
        logic        expSet;
        logic        expClr;
        logic        expDone;
        logic        expRdy;
        logic [11:0] expBus;
        logic [15:0] expTs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        initReq = 1'b0;
    logic        spikeValid = 1'b0;
    logic [11:0] spikeAddr = '0;
    logic        spikeReady;
    logic        timestepEnd = 1'b0;
    logic        setOut;
    logic        clearOut;
    logic [11:0] sourceAddress;
    logic        done;
    logic [15:0] timestepCount;
    logic        overflow;

    int          assertCount = 0;
    int          failCount = 0;
    vec_t        vecs[$];
    logic [11:0] sentQ[$];
    int          busViolations = 0;
    logic [11:0] prevBus = 12'hFFF;

    spike_dispatcher dut (
        .CLK            (clk),
        .rst_n          (rstN),
        .init_req       (initReq),
        .spike_valid    (spikeValid),
        .spike_addr     (spikeAddr),
        .spike_ready    (spikeReady),
        .timestep_end   (timestepEnd),
        .set_out        (setOut),
        .clear_out      (clearOut),
        .source_address (sourceAddress),
        .done           (done),
        .timestep_count (timestepCount),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Records every address that appears on the bus after an idle value and
    // counts cycles where an address is driven alongside set or clear.
    always @(negedge clk) begin
        if (sourceAddress != 12'hFFF) begin
            if (prevBus == 12'hFFF) begin
                sentQ.push_back(sourceAddress);
            end
            if (setOut || clearOut) begin
                busViolations <= busViolations + 1;
            end
        end
        prevBus <= sourceAddress;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        spikeValid  = v.valid;
        spikeAddr   = v.addr;
        timestepEnd = v.tend;
        tick();
    endtask

    function automatic void addVec(input logic valid, input logic [11:0] addr,
                                   input logic tend, input logic eSet,
                                   input logic eClr, input logic eDone,
                                   input logic eRdy, input logic [11:0] eBus,
                                   input logic [15:0] eTs);
        vec_t v;
        v.valid   = valid;
        v.addr    = addr;
        v.tend    = tend;
        v.expSet  = eSet;
        v.expClr  = eClr;
        v.expDone = eDone;
        v.expRdy  = eRdy;
        v.expBus  = eBus;
        v.expTs   = eTs;
        vecs.push_back(v);
    endfunction

    initial begin
        int          mainExp[5];
        int          fillStart;
        int          accepts;
        int          waited;
        int          sentBefore;
        logic        sawFull;
        logic        rdyNow;

        // Rows: inputs before an edge, expected outputs just after it.
        addVec(0, 12'd0,  0, 1, 0, 0, 0, 12'hFFF, 0);  // INIT
        addVec(0, 12'd0,  0, 1, 0, 0, 0, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 1, 0, 0, 0, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 0);  // IDLE, ready rises
        addVec(1, 12'd13, 0, 0, 0, 0, 1, 12'hFFF, 0);  // push 13
        addVec(1, 12'd14, 0, 0, 0, 0, 1, 12'd13,  0);  // push 14, 13 driven
        addVec(1, 12'd17, 0, 0, 0, 0, 1, 12'd13,  0);  // push 17
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd14,  0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd14,  0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd17,  0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd17,  0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 0);
        addVec(1, 12'd15, 1, 0, 0, 0, 1, 12'hFFF, 0);  // push 15 with end
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd15,  0);
        addVec(0, 12'd0,  1, 0, 0, 0, 1, 12'd15,  0);  // repeat end ignored
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 0, 1, 0, 1, 12'hFFF, 0);  // CLEAR
        addVec(0, 12'd0,  0, 0, 1, 0, 1, 12'hFFF, 0);
        addVec(1, 12'd20, 0, 0, 1, 0, 1, 12'hFFF, 0);  // push 20 in CLEAR
        addVec(0, 12'd0,  0, 0, 1, 0, 1, 12'hFFF, 0);
        addVec(0, 12'd0,  0, 0, 0, 1, 1, 12'hFFF, 1);  // DONE
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 1);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd20,  1);  // next timestep
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'd20,  1);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 1);
        addVec(0, 12'd0,  0, 0, 0, 0, 1, 12'hFFF, 1);

        mainExp = '{13, 14, 17, 15, 20};

        // Asynchronous reset and reset values.
        #2 rstN = 1'b0;
        tick();
        checkOutput("reset set_out", setOut, 1);
        checkOutput("reset clear_out", clearOut, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset spike_ready", spikeReady, 0);
        checkOutput("reset bus", sourceAddress, 12'hFFF);
        checkOutput("reset timestep_count", timestepCount, 0);
        checkOutput("reset overflow", overflow, 0);
        tick();
        rstN = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d set_out", i), setOut, vecs[i].expSet);
            checkOutput($sformatf("row%0d clear_out", i), clearOut, vecs[i].expClr);
            checkOutput($sformatf("row%0d done", i), done, vecs[i].expDone);
            checkOutput($sformatf("row%0d spike_ready", i), spikeReady, vecs[i].expRdy);
            checkOutput($sformatf("row%0d bus", i), sourceAddress, vecs[i].expBus);
            checkOutput($sformatf("row%0d timestep_count", i), timestepCount, vecs[i].expTs);
            checkOutput($sformatf("row%0d overflow", i), overflow, 0);
        end
        spikeValid  = 1'b0;
        timestepEnd = 1'b0;

        checkOutput("main send count", sentQ.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("main send %0d", i), (i < sentQ.size()) ? sentQ[i] : 12'h0,
                        mainExp[i]);
        end
        fillStart = sentQ.size();

        // Continuous pushes from an empty FIFO. Pops run once every three
        // cycles, so the FIFO fills after 12 accepts; the next attempt
        // overflows.
        accepts = 0;
        sawFull = 1'b0;
        for (int k = 0; k < 20 && !sawFull; k++) begin
            spikeValid = 1'b1;
            spikeAddr  = 12'(100 + accepts);
            rdyNow     = spikeReady;
            tick();
            if (rdyNow) begin
                accepts++;
                checkOutput($sformatf("fill no early overflow %0d", k), overflow, 0);
            end else begin
                sawFull = 1'b1;
            end
        end
        spikeValid = 1'b0;
        checkOutput("fill reached full", sawFull, 1);
        checkOutput("fill accepts", accepts, 12);
        checkOutput("overflow set", overflow, 1);

        waited = 0;
        while (sentQ.size() < fillStart + 12 && waited < 100) begin
            tick();
            waited++;
        end
        checkOutput("fill drained in time", (sentQ.size() >= fillStart + 12) ? 1 : 0, 1);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("fill order %0d", i),
                        (fillStart + i < sentQ.size()) ? sentQ[fillStart + i] : 12'h0,
                        100 + i);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("overflow sticky", overflow, 1);

        // init_req from IDLE re-runs the set sequence but keeps overflow.
        initReq = 1'b1;
        tick();
        initReq = 1'b0;
        checkOutput("init set_out", setOut, 1);
        checkOutput("init spike_ready", spikeReady, 0);
        checkOutput("init keeps overflow", overflow, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        checkOutput("init set_out held", setOut, 1);
        tick();
        checkOutput("init set_out falls", setOut, 0);
        checkOutput("init ready rises", spikeReady, 1);

        // Reset while 14 is on the bus with 33 still queued.
        spikeValid = 1'b1;
        spikeAddr  = 12'd14;
        tick();
        spikeAddr  = 12'd33;
        tick();
        spikeValid = 1'b0;
        checkOutput("pre-reset bus", sourceAddress, 12'd14);
        #2 rstN = 1'b0;
        #1;
        checkOutput("mid reset bus", sourceAddress, 12'hFFF);
        checkOutput("mid reset set_out", setOut, 1);
        checkOutput("mid reset spike_ready", spikeReady, 0);
        checkOutput("mid reset overflow", overflow, 0);
        checkOutput("mid reset timestep_count", timestepCount, 0);
        sentBefore = sentQ.size();
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("post reset set_out", setOut, 0);
        checkOutput("post reset ready", spikeReady, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("post reset bus idle %0d", i), sourceAddress, 12'hFFF);
        end
        checkOutput("post reset nothing sent", sentQ.size(), sentBefore);
        checkOutput("no address with set/clear", busViolations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
